wwm_projectile: RTL and testbench



---
 rtl/wwm_pkg.sv | 39 +++
 rtl/wwm_sat_add.sv | 36 +++
 rtl/wwm_projectile.sv | 174 +++++++++++++++++
 tb/tb_wwm_projectile.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wwm_pkg.sv
// rtl/wwm_pkg.sv - shared World War Math constants, Q-format widths and state encodings
//
// Purpose: common definitions for the projectile engine, the game state
//          machine and the VGA renderer.
// Ports:   none (package).
package wwm_pkg;

    // Q-format widths: positions are unsigned Q10.4, velocities signed Q8.4.
    localparam int POS_W  = 14;
    localparam int VEL_W  = 12;
    localparam int FRAC   = 4;
    localparam int PIX_W  = POS_W - FRAC;
    localparam int CALC_W = 16;
    localparam int FC_W   = 10;
    localparam int WIND_W = 4;

    // One-hot projectile states.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_FLIGHT = 4'b0010,
        ST_HIT    = 4'b0100,
        ST_MISS   = 4'b1000
    } state_t;

    // Screen, cannon and target defaults.
    localparam int DEF_START_X    = 200;
    localparam int DEF_START_Y    = 400;
    localparam int DEF_GRAVITY    = 2;
    localparam int DEF_MAX_FRAMES = 600;
    localparam int DEF_HIT_X_MIN  = 650;
    localparam int DEF_HIT_X_MAX  = 675;
    localparam int DEF_HIT_Y_MIN  = 470;
    localparam int DEF_HIT_Y_MAX  = 475;
    localparam int DEF_OOB_X_MIN  = 160;
    localparam int DEF_OOB_X_MAX  = 775;
    localparam int DEF_OOB_Y_MIN  = 50;
    localparam int DEF_OOB_Y_MAX  = 475;

endpackage

// File: rtl/wwm_sat_add.sv
// rtl/wwm_sat_add.sv - signed adder with saturation to a parameterized width
//
// Purpose: sum = clamp(a + b) into OUT_W bits, either signed
//          [-2^(OUT_W-1), 2^(OUT_W-1)-1] or unsigned [0, 2^OUT_W-1].
// Ports:   a, b - IN_W-bit signed operands
//          sum  - OUT_W-bit saturated result
module wwm_sat_add #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 14,
    parameter bit SIGNED_OUT = 1'b0
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic        [OUT_W-1:0] sum
);

    localparam int MAX_I = SIGNED_OUT ? (1 << (OUT_W - 1)) - 1 : (1 << OUT_W) - 1;
    localparam int MIN_I = SIGNED_OUT ? -(1 << (OUT_W - 1)) : 0;
    localparam logic signed [IN_W:0] MAX_V = (IN_W + 1)'(MAX_I);
    localparam logic signed [IN_W:0] MIN_V = (IN_W + 1)'(MIN_I);

    // One guard bit so the raw sum can never wrap before clamping.
    logic signed [IN_W:0] full;

    always_comb begin
        full = {a[IN_W-1], a} + {b[IN_W-1], b};
        if (full > MAX_V) begin
            sum = MAX_V[OUT_W-1:0];
        end else if (full < MIN_V) begin
            sum = MIN_V[OUT_W-1:0];
        end else begin
            sum = full[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/wwm_projectile.sv
// rtl/wwm_projectile.sv - projectile kinematics engine with hit / miss detection
//
// Purpose: launches from the cannon origin on Fire, integrates velocity and
//          gravity once per frame_tick, and reports a one-cycle hit or miss.
// Ports:   clk, Reset (sync, active-high), Fire, frame_tick
//          vel_x, vel_y        - signed Q8.4 launch velocity (vel_y > 0 is up)
//          wind                - signed 1/16 px/frame^2, only with WWM_PROJ_WIND_EN
//          projectileCenterX/Y - integer pixel position
//          active, hit, miss, frame_count
// Macro:   WWM_PROJ_WIND_EN adds the wind input and per-frame vx update.
module wwm_projectile
    import wwm_pkg::*;
#(
    parameter int START_X    = DEF_START_X,
    parameter int START_Y    = DEF_START_Y,
    parameter int GRAVITY    = DEF_GRAVITY,
    parameter int MAX_FRAMES = DEF_MAX_FRAMES,
    parameter int HIT_X_MIN  = DEF_HIT_X_MIN,
    parameter int HIT_X_MAX  = DEF_HIT_X_MAX,
    parameter int HIT_Y_MIN  = DEF_HIT_Y_MIN,
    parameter int HIT_Y_MAX  = DEF_HIT_Y_MAX,
    parameter int OOB_X_MIN  = DEF_OOB_X_MIN,
    parameter int OOB_X_MAX  = DEF_OOB_X_MAX,
    parameter int OOB_Y_MIN  = DEF_OOB_Y_MIN,
    parameter int OOB_Y_MAX  = DEF_OOB_Y_MAX
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Fire,
    input  logic              frame_tick,
    input  logic [VEL_W-1:0]  vel_x,
    input  logic [VEL_W-1:0]  vel_y,
`ifdef WWM_PROJ_WIND_EN
    input  logic [WIND_W-1:0] wind,
`endif
    output logic [PIX_W-1:0]  projectileCenterX,
    output logic [PIX_W-1:0]  projectileCenterY,
    output logic              active,
    output logic              hit,
    output logic              miss,
    output logic [FC_W-1:0]   frame_count
);

    localparam logic [POS_W-1:0]         X0       = POS_W'(START_X * 16);
    localparam logic [POS_W-1:0]         Y0       = POS_W'(START_Y * 16);
    localparam logic signed [CALC_W-1:0] GRAV_NEG = CALC_W'(-GRAVITY);
    localparam logic [FC_W-1:0]          MAXF     = FC_W'(MAX_FRAMES);
    localparam logic [PIX_W-1:0]         HX_MIN   = PIX_W'(HIT_X_MIN);
    localparam logic [PIX_W-1:0]         HX_MAX   = PIX_W'(HIT_X_MAX);
    localparam logic [PIX_W-1:0]         HY_MIN   = PIX_W'(HIT_Y_MIN);
    localparam logic [PIX_W-1:0]         HY_MAX   = PIX_W'(HIT_Y_MAX);
    localparam logic [PIX_W-1:0]         OX_MIN   = PIX_W'(OOB_X_MIN);
    localparam logic [PIX_W-1:0]         OX_MAX   = PIX_W'(OOB_X_MAX);
    localparam logic [PIX_W-1:0]         OY_MIN   = PIX_W'(OOB_Y_MIN);
    localparam logic [PIX_W-1:0]         OY_MAX   = PIX_W'(OOB_Y_MAX);

    state_t                    state;
    logic [POS_W-1:0]          pos_x;
    logic [POS_W-1:0]          pos_y;
    logic signed [VEL_W-1:0]   vx_r;
    logic signed [VEL_W-1:0]   vy_r;

    logic signed [CALC_W-1:0]  vx_ext;
    logic signed [CALC_W-1:0]  vy_ext;
    logic signed [CALC_W-1:0]  vy_neg;
    logic [POS_W-1:0]          x_next;
    logic [POS_W-1:0]          y_next;
    logic [VEL_W-1:0]          vy_next;
    logic [PIX_W-1:0]          px;
    logic [PIX_W-1:0]          py;
    logic                      in_hit;
    logic                      in_oob;

    assign vx_ext = {{(CALC_W - VEL_W){vx_r[VEL_W-1]}}, vx_r};
    assign vy_ext = {{(CALC_W - VEL_W){vy_r[VEL_W-1]}}, vy_r};
    // y grows downward while vy is positive-up, so y moves by -vy.
    assign vy_neg = -vy_ext;

    wwm_sat_add #(.IN_W(CALC_W), .OUT_W(POS_W), .SIGNED_OUT(1'b0)) u_add_x (
        .a   ({{(CALC_W - POS_W){1'b0}}, pos_x}),
        .b   (vx_ext),
        .sum (x_next)
    );

    wwm_sat_add #(.IN_W(CALC_W), .OUT_W(POS_W), .SIGNED_OUT(1'b0)) u_add_y (
        .a   ({{(CALC_W - POS_W){1'b0}}, pos_y}),
        .b   (vy_neg),
        .sum (y_next)
    );

    wwm_sat_add #(.IN_W(CALC_W), .OUT_W(VEL_W), .SIGNED_OUT(1'b1)) u_add_vy (
        .a   (vy_ext),
        .b   (GRAV_NEG),
        .sum (vy_next)
    );

`ifdef WWM_PROJ_WIND_EN
    logic [VEL_W-1:0] vx_next;

    wwm_sat_add #(.IN_W(CALC_W), .OUT_W(VEL_W), .SIGNED_OUT(1'b1)) u_add_vx (
        .a   (vx_ext),
        .b   ({{(CALC_W - WIND_W){wind[WIND_W-1]}}, wind}),
        .sum (vx_next)
    );
`endif

    // Checks use the registered position, so they trail the moving tick by a cycle.
    assign px     = pos_x[POS_W-1:FRAC];
    assign py     = pos_y[POS_W-1:FRAC];
    assign in_hit = (px >= HX_MIN) && (px <= HX_MAX) && (py >= HY_MIN) && (py <= HY_MAX);
    assign in_oob = (px <= OX_MIN) || (px >= OX_MAX) || (py <= OY_MIN) || (py >= OY_MAX);

    assign projectileCenterX = px;
    assign projectileCenterY = py;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            pos_x       <= X0;
            pos_y       <= Y0;
            vx_r        <= '0;
            vy_r        <= '0;
            frame_count <= '0;
            active      <= 1'b0;
            hit         <= 1'b0;
            miss        <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Fire) begin
                        vx_r        <= vel_x;
                        vy_r        <= vel_y;
                        pos_x       <= X0;
                        pos_y       <= Y0;
                        frame_count <= '0;
                        active      <= 1'b1;
                        state       <= ST_FLIGHT;
                    end
                end
                ST_FLIGHT: begin
                    // Hit wins over miss; a tick landing on the exit cycle is dropped.
                    if (in_hit) begin
                        hit    <= 1'b1;
                        active <= 1'b0;
                        state  <= ST_HIT;
                    end else if (in_oob || (frame_count >= MAXF)) begin
                        miss   <= 1'b1;
                        active <= 1'b0;
                        state  <= ST_MISS;
                    end else if (frame_tick) begin
                        pos_x <= x_next;
                        pos_y <= y_next;
                        vy_r  <= vy_next;
`ifdef WWM_PROJ_WIND_EN
                        vx_r  <= vx_next;
`endif
                        if (frame_count != '1) begin
                            frame_count <= frame_count + 1'b1;
                        end
                    end
                end
                ST_HIT, ST_MISS: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wwm_projectile.sv
// tb/tb_wwm_projectile.sv - self-checking bench for wwm_projectile
module tb_wwm_projectile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fire;
    logic        tick;
    logic [11:0] vx_in;
    logic [11:0] vy_in;
`ifdef WWM_PROJ_WIND_EN
    logic [3:0]  wind_in;
`endif

    // Instance 0: defaults (gravity 2); 1: gravity 0; 2: gravity 0, 8-frame timeout.
    logic [9:0] dx [3];
    logic [9:0] dy [3];
    logic [9:0] dfc [3];
    logic       dact [3];
    logic       dhit [3];
    logic       dmiss [3];

    wwm_projectile #(.GRAVITY(2)) u_g (
        .clk(clk), .Reset(rst), .Fire(fire), .frame_tick(tick), .vel_x(vx_in), .vel_y(vy_in),
`ifdef WWM_PROJ_WIND_EN
        .wind(wind_in),
`endif
        .projectileCenterX(dx[0]), .projectileCenterY(dy[0]), .active(dact[0]),
        .hit(dhit[0]), .miss(dmiss[0]), .frame_count(dfc[0])
    );

    wwm_projectile #(.GRAVITY(0)) u_z (
        .clk(clk), .Reset(rst), .Fire(fire), .frame_tick(tick), .vel_x(vx_in), .vel_y(vy_in),
`ifdef WWM_PROJ_WIND_EN
        .wind(wind_in),
`endif
        .projectileCenterX(dx[1]), .projectileCenterY(dy[1]), .active(dact[1]),
        .hit(dhit[1]), .miss(dmiss[1]), .frame_count(dfc[1])
    );

    wwm_projectile #(.GRAVITY(0), .MAX_FRAMES(8)) u_m (
        .clk(clk), .Reset(rst), .Fire(fire), .frame_tick(tick), .vel_x(vx_in), .vel_y(vy_in),
`ifdef WWM_PROJ_WIND_EN
        .wind(wind_in),
`endif
        .projectileCenterX(dx[2]), .projectileCenterY(dy[2]), .active(dact[2]),
        .hit(dhit[2]), .miss(dmiss[2]), .frame_count(dfc[2])
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: positions in 1/16 px, phase 0 idle, 1 flying, 2 reporting.
    localparam int P_GRAV [3] = '{2, 0, 0};
    localparam int P_MAXF [3] = '{600, 600, 8};
    int m_x [3];
    int m_y [3];
    int m_vx [3];
    int m_vy [3];
    int m_fc [3];
    int m_ph [3];
    bit m_hit [3];
    bit m_miss [3];

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_step();
        int px;
        int py;
        int w;
`ifdef WWM_PROJ_WIND_EN
        w = $signed(wind_in);
`else
        w = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_x[i] = 200 * 16; m_y[i] = 400 * 16; m_vx[i] = 0; m_vy[i] = 0;
                m_fc[i] = 0; m_ph[i] = 0; m_hit[i] = 0; m_miss[i] = 0;
            end else begin
                m_hit[i] = 0;
                m_miss[i] = 0;
                px = m_x[i] / 16;
                py = m_y[i] / 16;
                if (m_ph[i] == 0) begin
                    if (fire) begin
                        m_vx[i] = $signed(vx_in); m_vy[i] = $signed(vy_in);
                        m_x[i] = 200 * 16; m_y[i] = 400 * 16; m_fc[i] = 0; m_ph[i] = 1;
                    end
                end else if (m_ph[i] == 2) begin
                    m_ph[i] = 0;
                end else if (px >= 650 && px <= 675 && py >= 470 && py <= 475) begin
                    m_ph[i] = 2; m_hit[i] = 1;
                end else if (px <= 160 || px >= 775 || py <= 50 || py >= 475 || m_fc[i] >= P_MAXF[i]) begin
                    m_ph[i] = 2; m_miss[i] = 1;
                end else if (tick) begin
                    m_x[i]  = clamp(m_x[i] + m_vx[i], 0, 16383);
                    m_y[i]  = clamp(m_y[i] - m_vy[i], 0, 16383);
                    m_vy[i] = clamp(m_vy[i] - P_GRAV[i], -2048, 2047);
                    m_vx[i] = clamp(m_vx[i] + w, -2048, 2047);
                    m_fc[i] = clamp(m_fc[i] + 1, 0, 1023);
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [32:0] e;
        logic [32:0] a;
        for (int i = 0; i < 3; i++) begin
            e = {10'(m_x[i] / 16), 10'(m_y[i] / 16), (m_ph[i] == 1), m_hit[i], m_miss[i], 10'(m_fc[i])};
            a = {dx[i], dy[i], dact[i], dhit[i], dmiss[i], dfc[i]};
            chk($sformatf("model_inst%0d {x,y,act,hit,miss,fc}", i), 64'(a), 64'(e));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic do_fire(input logic [11:0] vx, input logic [11:0] vy);
        vx_in = vx;
        vy_in = vy;
        fire = 1'b1;
        cycle();
        fire = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
    endtask

    typedef struct {
        int          inst;
        logic [11:0] vx;
        logic [11:0] vy;
        int          ticks;
        int          ex;
        int          ey;
        int          efc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; fire = 1'b0; tick = 1'b0; vx_in = '0; vy_in = '0;
`ifdef WWM_PROJ_WIND_EN
        wind_in = '0;
`endif
        vecs[0] = '{1, 12'h0A0, 12'h000, 1, 210, 400, 1};
        vecs[1] = '{1, 12'h0A0, 12'h000, 57, 770, 400, 57};
        vecs[2] = '{1, 12'h0A0, 12'hFE7, 45, 650, 470, 45};
        vecs[3] = '{0, 12'h000, 12'h040, 1, 200, 396, 1};
        vecs[4] = '{0, 12'h000, 12'h040, 2, 200, 392, 2};
        vecs[5] = '{0, 12'h000, 12'h040, 3, 200, 388, 3};
        vecs[6] = '{2, 12'h000, 12'h000, 8, 200, 400, 8};

        // Reset state.
        do_reset();
        chk("reset_x", dx[1], 200);
        chk("reset_y", dy[1], 400);
        chk("reset_active", dact[1], 0);
        chk("reset_hit", dhit[1], 0);
        chk("reset_miss", dmiss[1], 0);
        chk("reset_fc", dfc[1], 0);

        // Reset mid-flight.
        do_fire(12'h0A0, 12'h000);
        chk("fire_active", dact[1], 1);
        repeat (5) do_tick();
        chk("pre_reset_x", dx[1], 250);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_x", dx[1], 200);
        chk("midrst_y", dy[1], 400);
        chk("midrst_active", dact[1], 0);

        // Table of launch vectors.
        foreach (vecs[k]) begin
            do_reset();
            do_fire(vecs[k].vx, vecs[k].vy);
            repeat (vecs[k].ticks) do_tick();
            chk($sformatf("vec%0d_x", k), dx[vecs[k].inst], vecs[k].ex);
            chk($sformatf("vec%0d_y", k), dy[vecs[k].inst], vecs[k].ey);
            chk($sformatf("vec%0d_fc", k), dfc[vecs[k].inst], vecs[k].efc);
        end

        // Right-edge miss after tick 58.
        do_reset();
        do_fire(12'h0A0, 12'h000);
        repeat (57) do_tick();
        chk("edge_x57", dx[1], 770);
        chk("edge_nomiss57", dmiss[1], 0);
        chk("edge_active57", dact[1], 1);
        do_tick();
        chk("edge_x58", dx[1], 780);
        chk("edge_miss58", dmiss[1], 1);
        chk("edge_active58", dact[1], 0);
        cycle();
        chk("edge_miss_pulse_end", dmiss[1], 0);
        chk("edge_x_held", dx[1], 780);

        // Target hit and position freeze.
        do_reset();
        do_fire(12'h0A0, 12'hFE7);
        repeat (44) do_tick();
        chk("hit_none44", dhit[1], 0);
        do_tick();
        chk("hit_pulse45", dhit[1], 1);
        chk("hit_nomiss45", dmiss[1], 0);
        cycle();
        chk("hit_pulse_end", dhit[1], 0);
        repeat (5) begin
            do_tick();
            chk("hit_freeze_miss", dmiss[1], 0);
        end
        chk("hit_freeze_x", dx[1], 650);
        chk("hit_freeze_y", dy[1], 470);

        // Timeout with Fire pulses during flight.
        do_reset();
        do_fire(12'h000, 12'h000);
        repeat (3) do_tick();
        fire = 1'b1;
        cycle();
        fire = 1'b0;
        chk("to_fc_after_fire", dfc[2], 3);
        repeat (4) do_tick();
        chk("to_nomiss7", dmiss[2], 0);
        do_tick();
        chk("to_miss8", dmiss[2], 1);
        chk("to_fc8", dfc[2], 8);

        // Gravity arc descends to the floor.
        do_reset();
        do_fire(12'h000, 12'h040);
        n = 0;
        while (n < 200 && !dmiss[0]) begin
            do_tick();
            n++;
        end
        chk("grav_ticks_to_floor", n, 80);
        chk("grav_floor_y", dy[0], 475);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            fire = ($urandom_range(0, 19) == 0);
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                vx_in = 12'($urandom);
                vy_in = 12'($urandom);
            end else begin
                vx_in = 12'($urandom_range(0, 400) - 200);
                vy_in = 12'($urandom_range(0, 400) - 200);
            end
`ifdef WWM_PROJ_WIND_EN
            wind_in = 4'($urandom);
`endif
            cycle();
        end
        rst = 1'b0; fire = 1'b0; tick = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
